// File: rtl/uart_pkg.sv
// Shared constants for the firn UART: register offsets, STATUS bit positions
// and TX state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_LVL_LO = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port; push while full and pop while
// empty are ignored, so callers may drive them unconditionally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_level = r_cnt;
  assign o_dout  = r_mem[r_rptr];

  // Gating uses pre-edge full/empty, so a push into a full FIFO is lost even
  // if a pop happens on the same edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone-mapped 8N1 UART transmitter: register decode, TX FIFO and the
// serialiser FSM for the firn console.
module uart_tx_wb
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int DIV_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        txd,
  output logic        irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

  logic                 r_ack;
  logic [31:0]          r_dat;
  logic                 r_ovf;
  logic [DIV_WIDTH-1:0] r_div;
  logic [1:0]           r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_fdiv;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_txd;
  logic                 r_irq;

  logic                 w_req;
  logic [1:0]           w_adr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_dout;
  logic [LW-1:0]        w_level;
  logic [31:0]          w_rdata;
  logic [DIV_WIDTH-1:0] w_div_new;
  logic                 w_period_end;
  logic                 w_unused;

  assign w_req = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_adr = wbs_adr_i[3:2];
  assign w_unused = ^{wbs_adr_i, wbs_dat_i};

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign txd       = r_txd;
  assign irq_o     = r_irq;

  assign w_push = w_req & wbs_we_i & (w_adr == REG_TXDATA) & wbs_sel_i[0];
  assign w_period_end = (r_cnt == '0);
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                             ((r_state == ST_STOP) & w_period_end));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (wbs_dat_i[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      REG_STATUS: begin
        w_rdata[STAT_FULL]  = w_full;
        w_rdata[STAT_EMPTY] = w_empty;
        w_rdata[STAT_BUSY]  = (r_state != ST_IDLE);
        w_rdata[STAT_OVF]   = r_ovf;
        w_rdata[STAT_LVL_LO +: 8] = 8'(w_level);
      end
      REG_BAUDDIV: w_rdata[DIV_WIDTH-1:0] = r_div;
      default: w_rdata = '0;
    endcase
  end

  // Byte-lane merge into the divider, then clamp: a divider below 2 would
  // leave no room for the counter to reload.
  always_comb begin
    w_div_new = r_div;
    for (int i = 0; i < DIV_WIDTH; i++)
      if (wbs_sel_i[i/8]) w_div_new[i] = wbs_dat_i[i];
    if (w_div_new < DIV_MIN) w_div_new = DIV_MIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_ovf <= 1'b0;
      r_div <= DIV_WIDTH'(CLKS_PER_BIT);
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_dat <= wbs_we_i ? '0 : w_rdata;
        if (wbs_we_i) begin
          case (w_adr)
            REG_TXDATA:  if (wbs_sel_i[0] && w_full) r_ovf <= 1'b1;
            REG_STATUS:  if (wbs_dat_i[STAT_OVF]) r_ovf <= 1'b0;
            REG_BAUDDIV: r_div <= w_div_new;
            default:     ;
          endcase
        end
      end
    end
  end

  // The divider is latched per frame so BAUDDIV writes never stretch or
  // shrink a frame already on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_txd   <= 1'b1;
      r_cnt   <= '0;
      r_fdiv  <= DIV_WIDTH'(CLKS_PER_BIT);
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_state <= ST_START;
            r_txd   <= 1'b0;
            r_shift <= w_dout;
            r_fdiv  <= r_div;
            r_cnt   <= r_div - DIV_ONE;
          end
        end
        ST_START: begin
          if (w_period_end) begin
            r_state <= ST_DATA;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
            r_cnt   <= r_fdiv - DIV_ONE;
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        ST_DATA: begin
          if (w_period_end) begin
            r_cnt <= r_fdiv - DIV_ONE;
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        ST_STOP: begin
          if (w_period_end) begin
            if (!w_empty) begin
              r_state <= ST_START;
              r_txd   <= 1'b0;
              r_shift <= w_dout;
              r_fdiv  <= r_div;
              r_cnt   <= r_div - DIV_ONE;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b1;
    else     r_irq <= w_empty & (r_state == ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_wb.sv
// Directed bench for uart_tx_wb: register access, frame timing, back-to-back
// frames, FIFO overflow, divider changes and mid-frame reset.
module tb_uart_tx_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack, txd, irq;
  logic [31:0] rd;
  int          nvec = 0, nerr = 0;
  logic        low_seen;

  localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_DIV = 32'h8, A_RSV = 32'hC;

  always #5 clk = ~clk;

  uart_tx_wb #(.FIFO_DEPTH(8), .CLKS_PER_BIT(104), .DIV_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_sel_i (sel),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .txd       (txd),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Returns 1ns after the edge that registered ack, i.e. edge E of the request.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 4);
    chk("ack", {31'b0, ack}, 32'h1);
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, 4'hF, r);
  endtask

  // One 8N1 frame, one sample per cycle on negedges.
  task automatic chk_frame(input logic [7:0] b, input int div);
    logic e;
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        chk($sformatf("txd_%02h_b%0d_c%0d", b, i, c), {31'b0, txd}, {31'b0, e});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h1);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    wb_rd(A_ST, rd);  chk("rst_status", rd, 32'h0000_0002);
    wb_rd(A_DIV, rd); chk("rst_div", rd, 32'd104);
    @(negedge clk); chk("ack_hi", {31'b0, ack}, 32'h1);
    @(negedge clk); chk("ack_one_cycle", {31'b0, ack}, 32'h0);

    // divider clamp and reserved slot
    wb_wr(A_DIV, 32'h0);        wb_rd(A_DIV, rd); chk("div_clamp0", rd, 32'd2);
    wb_wr(A_DIV, 32'h1);        wb_rd(A_DIV, rd); chk("div_clamp1", rd, 32'd2);
    wb_wr(A_RSV, 32'hFFFF_FFFF); wb_rd(A_DIV, rd); chk("rsv_wr_ignored", rd, 32'd2);
    wb_rd(A_RSV, rd); chk("rsv_rd", rd, 32'h0);
    wb_rd(A_TX, rd);  chk("txdata_rd", rd, 32'h0);

    // single frame 0xA5 at div 4, txd falls at E+1
    wb_wr(A_DIV, 32'd4);
    wb_wr(A_TX, 32'hA5);
    @(negedge clk); chk("a5_latency", {31'b0, txd}, 32'h1);
    chk_frame(8'hA5, 4);
    repeat (3) @(negedge clk);
    chk("a5_irq_done", {31'b0, irq}, 32'h1);
    chk("a5_txd_idle", {31'b0, txd}, 32'h1);

    // back-to-back 0x00, 0xFF at div 2: contiguous 40 cycles, busy throughout
    wb_wr(A_DIV, 32'd2);
    wb_wr(A_TX, 32'h00);
    fork
      begin
        @(negedge clk); chk("b2b_latency", {31'b0, txd}, 32'h1);
        chk_frame(8'h00, 2);
        chk_frame(8'hFF, 2);
      end
      begin
        logic [31:0] r2;
        wb_wr(A_TX, 32'hFF);
        for (int k = 0; k < 6; k++) begin
          wb_rd(A_ST, r2);
          chk($sformatf("b2b_busy%0d", k), {31'b0, r2[2]}, 32'h1);
        end
      end
    join
    repeat (3) @(negedge clk);
    wb_rd(A_ST, rd); chk("b2b_status_idle", rd, 32'h0000_0002);

    // divider change mid-frame: 0x5A keeps div 4, 0x81 uses div 2
    wb_wr(A_DIV, 32'd4);
    wb_wr(A_TX, 32'h5A);
    fork
      begin
        @(negedge clk); chk("chg_latency", {31'b0, txd}, 32'h1);
        chk_frame(8'h5A, 4);
        chk_frame(8'h81, 2);
      end
      begin
        logic [31:0] r3;
        wb_wr(A_TX, 32'h81);
        wb_wr(A_DIV, 32'd2);
        wb_rd(A_RSV, r3); chk("rsv_rd_busy", r3, 32'h0);
        wb_rd(A_DIV, r3); chk("div_readback", r3, 32'd2);
      end
    join
    repeat (3) @(negedge clk);

    // overflow at div 1000: 1 in flight, 8 queued, 10th dropped
    wb_wr(A_DIV, 32'd1000);
    for (int k = 0; k < 10; k++) wb_wr(A_TX, 32'h10 + k);
    wb_rd(A_ST, rd); chk("ovf_status", rd, 32'h0000_080D);
    wb_wr(A_ST, 32'h8);
    wb_rd(A_ST, rd); chk("ovf_cleared", rd, 32'h0000_0805);
    chk("ovf_txd_start", {31'b0, txd}, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("ovf_rst_txd", {31'b0, txd}, 32'h1);
    chk("ovf_rst_irq", {31'b0, irq}, 32'h1);
    wb_rd(A_ST, rd);  chk("ovf_rst_status", rd, 32'h0000_0002);
    wb_rd(A_DIV, rd); chk("ovf_rst_div", rd, 32'd104);

    // mid-frame reset during bit 3 of 0x3C at div 4
    wb_wr(A_DIV, 32'd4);
    wb_wr(A_TX, 32'h3C);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("3c_bit0", {31'b0, txd}, 32'h0);
    repeat (11) @(negedge clk);
    chk("3c_bit2", {31'b0, txd}, 32'h1);
    @(negedge clk);
    chk("3c_bit3", {31'b0, txd}, 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("3c_rst_txd", {31'b0, txd}, 32'h1);
    wb_rd(A_ST, rd); chk("3c_rst_status", rd, 32'h0000_0002);
    low_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!txd) low_seen = 1'b1;
    end
    chk("3c_no_more_frame", {31'b0, low_seen}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
